pc_sequencer: RTL and testbench

- Multi-cycle fetch/execute controller for the PC register. Drives the PC register's write-enable and next-address inputs.
- Runs the instruction-memory fetch handshake and waits for datapath completion.
- Picks the next PC by priority: exception > jump > branch > sequential.
- The PC register loads `next_pc + 4` when `pc_wre` is high, so this block always presents `target - 4`.

---
 rtl/pc_sequencer.sv | 151 +++++++++++++++
 tb/tb_pc_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/execute sequencer that drives the PC register's write-enable and next address.
// Optional build macro PC_MISALIGN_TRAP_EN turns misaligned jump/branch targets into exceptions.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      cur_pc,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic             exec_done,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    input  logic             exc_req,
    input  logic             halt,
    output logic             pc_wre,
    output logic [31:0]      next_pc,
    output logic [31:0]      epc,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             misalign
);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StFetch  = 2'b01,
        StExec   = 2'b10,
        StUpdate = 2'b11
    } state_e;

    // The PC register adds 4 on load, so a misaligned reset PC can never be reached.
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("RESET_PC must be word aligned");
    end

    state_e           state_q, state_d;
    logic             halted_q, halted_d;
    logic             imem_req_q, imem_req_d;
    logic             pc_wre_q, pc_wre_d;
    logic [31:0]      next_pc_q, next_pc_d;
    logic [31:0]      epc_q, epc_d;
    logic [CNT_W-1:0] retire_q, retire_d;
    logic             misalign_q, misalign_d;

    logic [31:0] redirect;
    logic        redirect_en;
    logic        tgt_misaligned;

    assign redirect_en = jump | branch_taken;
    assign redirect    = jump ? jump_target : branch_target;

`ifdef PC_MISALIGN_TRAP_EN
    assign tgt_misaligned = redirect[1:0] != 2'b00;
`else
    assign tgt_misaligned = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        halted_d   = halted_q;
        imem_req_d = 1'b0;
        pc_wre_d   = 1'b0;
        next_pc_d  = next_pc_q;
        epc_d      = epc_q;
        retire_d   = retire_q;
        misalign_d = misalign_q;

        unique case (state_q)
            StIdle: begin
                if (!halted_q) begin
                    state_d    = StFetch;
                    imem_req_d = 1'b1;
                end
            end
            StFetch: begin
                if (imem_ack) begin
                    state_d = StExec;
                end else begin
                    imem_req_d = 1'b1;
                end
            end
            StExec: begin
                if (exec_done && !stall) begin
                    state_d  = StUpdate;
                    pc_wre_d = 1'b1;
                    if (exc_req) begin
                        next_pc_d = EXC_VECTOR - 32'd4;
                        epc_d     = cur_pc;
                    end else if (halt) begin
                        retire_d = retire_q + CNT_W'(1);
                        halted_d = 1'b1;
                        state_d  = StIdle;
                        pc_wre_d = 1'b0;
                    end else if (redirect_en && tgt_misaligned) begin
                        next_pc_d  = EXC_VECTOR - 32'd4;
                        epc_d      = cur_pc;
                        misalign_d = 1'b1;
                    end else if (redirect_en) begin
                        next_pc_d = redirect - 32'd4;
                        retire_d  = retire_q + CNT_W'(1);
                    end else begin
                        // PC register adds 4, so presenting cur_pc yields the sequential PC.
                        next_pc_d = cur_pc;
                        retire_d  = retire_q + CNT_W'(1);
                    end
                end
            end
            StUpdate: begin
                state_d    = StFetch;
                imem_req_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            halted_q   <= 1'b0;
            imem_req_q <= 1'b0;
            pc_wre_q   <= 1'b0;
            next_pc_q  <= 32'd0;
            epc_q      <= 32'd0;
            retire_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            halted_q   <= halted_d;
            imem_req_q <= imem_req_d;
            pc_wre_q   <= pc_wre_d;
            next_pc_q  <= next_pc_d;
            epc_q      <= epc_d;
            retire_q   <= retire_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign pc_wre     = pc_wre_q;
    assign next_pc    = next_pc_q;
    assign epc        = epc_q;
    assign state      = state_q;
    assign retire_cnt = retire_q;
    assign misalign   = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: vector table of single instructions plus stall, halt and
// reset corner-case sequences.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cur_pc;
    logic        imem_req;
    logic        imem_ack;
    logic        exec_done;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        exc_req;
    logic        halt;
    logic        pc_wre;
    logic [31:0] next_pc;
    logic [31:0] epc;
    logic [1:0]  state;
    logic [31:0] retire_cnt;
    logic        misalign;

    int errors = 0;
    int checks = 0;

    pc_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .cur_pc       (cur_pc),
        .imem_req     (imem_req),
        .imem_ack     (imem_ack),
        .exec_done    (exec_done),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .exc_req      (exc_req),
        .halt         (halt),
        .pc_wre       (pc_wre),
        .next_pc      (next_pc),
        .epc          (epc),
        .state        (state),
        .retire_cnt   (retire_cnt),
        .misalign     (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        jmp;
        logic [31:0] jt;
        logic        br;
        logic [31:0] bt;
        logic        exc;
        logic        hlt;
        int          ack_dly;
        logic [31:0] exp_next;
        logic [31:0] exp_epc;
        logic [31:0] exp_ret;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        imem_ack      = 1'b0;
        exec_done     = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        jump          = 1'b0;
        jump_target   = 32'd0;
        exc_req       = 1'b0;
        halt          = 1'b0;
    endtask

    task automatic check_reset_values();
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_pc_wre", {31'd0, pc_wre}, 32'd0);
        chk("rst_next_pc", next_pc, 32'd0);
        chk("rst_epc", epc, 32'd0);
        chk("rst_retire", retire_cnt, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_state", {30'd0, state}, 32'd0);
    endtask

    // Waits (bounded) for FETCH, then acks after ack_dly idle FETCH cycles. Ends at a negedge in EXEC.
    task automatic fetch_phase(input int ack_dly);
        int cyc;
        int req_cycles;
        cyc = 0;
        while (state !== 2'b01 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("fetch_entry", {30'd0, state}, 32'd1);
        req_cycles = 0;
        for (int i = 0; i <= ack_dly; i++) begin
            if (imem_req === 1'b1) req_cycles++;
            if (i == ack_dly) imem_ack = 1'b1;
            @(negedge clk);
        end
        imem_ack = 1'b0;
        chk("req_cycles", req_cycles, ack_dly + 1);
        chk("exec_state", {30'd0, state}, 32'd2);
        chk("req_dropped", {31'd0, imem_req}, 32'd0);
    endtask

    task automatic do_instr(input vec_t v);
        logic [31:0] held;
        fetch_phase(v.ack_dly);
        cur_pc        = v.pc;
        jump          = v.jmp;
        jump_target   = v.jt;
        branch_taken  = v.br;
        branch_target = v.bt;
        exc_req       = v.exc;
        halt          = v.hlt;
        exec_done     = 1'b1;
        @(negedge clk);
        clear_inputs();
        chk("update_state", {30'd0, state}, 32'd3);
        chk("pc_wre_pulse", {31'd0, pc_wre}, 32'd1);
        chk("next_pc", next_pc, v.exp_next);
        chk("epc", epc, v.exp_epc);
        chk("retire_cnt", retire_cnt, v.exp_ret);
        chk("misalign", {31'd0, misalign}, {31'd0, v.exp_mis});
        held = next_pc;
        @(negedge clk);
        chk("pc_wre_drop", {31'd0, pc_wre}, 32'd0);
        chk("refetch_state", {30'd0, state}, 32'd1);
        chk("next_pc_hold", next_pc, v.exp_next);
        chk("refetch_req", {31'd0, imem_req}, 32'd1);
    endtask

    initial begin
        logic [31:0] exp_ret;
        logic [31:0] exp_epc;

        //          pc     jmp jt        br  bt         exc hlt dly next          epc      ret  mis
        vecs[0] = '{32'h00, 0, 32'h00,   0, 32'h00,    0,  0,  2, 32'h0000_0000, 32'h00,  1,   0};
        vecs[1] = '{32'h10, 1, 32'h40,   1, 32'h80,    0,  0,  0, 32'h0000_003C, 32'h00,  2,   0};
        vecs[2] = '{32'h24, 1, 32'h40,   0, 32'h00,    1,  0,  1, 32'h0000_007C, 32'h24,  2,   0};
        vecs[3] = '{32'h80, 0, 32'h00,   1, 32'h100,   0,  0,  0, 32'h0000_00FC, 32'h24,  3,   0};
        vecs[4] = '{32'h100, 1, 32'h00,  0, 32'h00,    0,  0,  3, 32'hFFFF_FFFC, 32'h24,  4,   0};
        vecs[5] = '{32'h200, 0, 32'h00,  0, 32'h00,    1,  1,  0, 32'h0000_007C, 32'h200, 4,   0};
`ifdef PC_MISALIGN_TRAP_EN
        vecs[6] = '{32'h30, 0, 32'h00,   1, 32'h42,    0,  0,  0, 32'h0000_007C, 32'h30,  4,   1};
        vecs[7] = '{32'h40, 0, 32'h00,   0, 32'h99,    0,  0,  1, 32'h0000_0040, 32'h30,  5,   1};
`else
        vecs[6] = '{32'h30, 0, 32'h00,   1, 32'h42,    0,  0,  0, 32'h0000_003E, 32'h200, 5,   0};
        vecs[7] = '{32'h40, 0, 32'h00,   0, 32'h99,    0,  0,  1, 32'h0000_0040, 32'h200, 6,   0};
`endif

        cur_pc = 32'd0;
        clear_inputs();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values();
        reset = 1'b0;

        for (int i = 0; i < 8; i++) do_instr(vecs[i]);
        exp_ret = vecs[7].exp_ret;
        exp_epc = vecs[7].exp_epc;

        // Stall holds EXEC even with exec_done high; completion follows the stall drop.
        fetch_phase(0);
        cur_pc    = 32'h50;
        exec_done = 1'b1;
        stall     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_state", {30'd0, state}, 32'd2);
            chk("stall_pc_wre", {31'd0, pc_wre}, 32'd0);
        end
        stall = 1'b0;
        @(negedge clk);
        clear_inputs();
        exp_ret = exp_ret + 1;
        chk("stall_done_state", {30'd0, state}, 32'd3);
        chk("stall_done_wre", {31'd0, pc_wre}, 32'd1);
        chk("stall_next_pc", next_pc, 32'h50);
        chk("stall_retire", retire_cnt, exp_ret);

        // Halt: retires, never pulses pc_wre, parks in IDLE until reset.
        fetch_phase(0);
        cur_pc    = 32'h60;
        halt      = 1'b1;
        jump      = 1'b1;
        jump_target = 32'h400;
        exec_done = 1'b1;
        @(negedge clk);
        clear_inputs();
        exp_ret = exp_ret + 1;
        chk("halt_state", {30'd0, state}, 32'd0);
        chk("halt_retire", retire_cnt, exp_ret);
        chk("halt_next_pc", next_pc, 32'h50);
        chk("halt_epc", epc, exp_epc);
        for (int i = 0; i < 6; i++) begin
            chk("halt_pc_wre", {31'd0, pc_wre}, 32'd0);
            chk("halt_parked", {30'd0, state}, 32'd0);
            chk("halt_no_req", {31'd0, imem_req}, 32'd0);
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        check_reset_values();
        reset = 1'b0;
        @(negedge clk);
        chk("restart_state", {30'd0, state}, 32'd1);
        chk("restart_req", {31'd0, imem_req}, 32'd1);

        // Reset during FETCH with a late ack: ack must be dropped.
        @(negedge clk);
        chk("pre_rst_fetch", {30'd0, state}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values();
        imem_ack = 1'b1;
        @(negedge clk);
        chk("late_ack_state", {30'd0, state}, 32'd0);
        chk("late_ack_req", {31'd0, imem_req}, 32'd0);
        reset    = 1'b0;
        imem_ack = 1'b0;
        @(negedge clk);
        chk("post_rst_fetch", {30'd0, state}, 32'd1);
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
        chk("post_rst_wre", {31'd0, pc_wre}, 32'd0);
        chk("post_rst_retire", retire_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
